handshake_const_sink: RTL and testbench

Elastic-circuit token consumer terminating a valid/ready data channel, the receiving end of a constant-producing handshake source. It accepts tokens, compares each against a parameterised expected constant, counts accepted tokens and mismatches, and applies a programmable periodic backpressure pattern so producers are exercised under stall. It sits at channel sinks in generated dataflow netlists and in self-checking on-chip test harnesses.

---
 rtl/handshake_const_sink_pkg.sv | 12 +
 rtl/handshake_const_sink_if.sv | 13 +
 rtl/handshake_const_sink_sat_counter.sv | 27 ++
 rtl/handshake_const_sink.sv | 137 +++++++++++++
 tb/tb_handshake_const_sink.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_const_sink_pkg.sv
// Shared definitions for the constant-token sink: FSM state type and default count width.
package handshake_pkg;

  localparam int unsigned DEFAULT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DONE  = 2'd2
  } sink_state_e;

endpackage

// File: rtl/handshake_const_sink_if.sv
// Valid/ready data channel feeding handshake_const_sink.
interface handshake_const_sink_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;

  modport master (output ins, output ins_valid, input ins_ready);
  modport slave  (input ins, input ins_valid, output ins_ready);

endinterface

// File: rtl/handshake_const_sink_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module handshake_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count increments, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/handshake_const_sink.sv
// Constant-checking token sink with periodic backpressure.
// Optional macro HANDSHAKE_CONST_SINK_CAPTURE_EN: records data and index of the
// first mismatching token; without it first_bad_data/first_bad_idx read as 0.
module handshake_const_sink
  import handshake_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED     = 32'h4923_0CBB,
  parameter int unsigned           EXPECT_COUNT = 16,
  parameter int unsigned           CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter int unsigned           STALL_PERIOD = 0,
  parameter int unsigned           STALL_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_const_sink_if.slave   s_if,
  output logic [CNT_WIDTH-1:0]    token_count,
  output logic [CNT_WIDTH-1:0]    mismatch_count,
  output logic                    error,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   first_bad_data,
  output logic [CNT_WIDTH-1:0]    first_bad_idx
);

  localparam bit STALL_EN = (STALL_PERIOD != 0) && (STALL_CYCLES != 0);

  sink_state_e r_state;
  sink_state_e w_state_nxt;
  logic [31:0] r_period_cnt;
  logic [31:0] w_period_nxt;
  logic [31:0] r_stall_cnt;
  logic [31:0] w_stall_nxt;
  logic        r_error;
  logic        w_xfer;
  logic        w_mismatch;
  logic        w_last;

  assign s_if.ins_ready = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign error          = r_error;

  assign w_xfer     = s_if.ins_valid & s_if.ins_ready;
  assign w_mismatch = w_xfer && (s_if.ins != EXPECTED);
  // Compared on the registered (possibly saturated) count, so a saturated
  // narrow counter never reaches a larger EXPECT_COUNT.
  assign w_last     = ((32'(token_count) + 32'd1) == 32'(EXPECT_COUNT));

  // State, period and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RUN;
      r_period_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_period_cnt <= w_period_nxt;
      r_stall_cnt  <= w_stall_nxt;
    end
  end

  // Next-state logic: completion takes priority over entering a stall window.
  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period_cnt;
    w_stall_nxt  = r_stall_cnt;
    case (r_state)
      RUN: begin
        if (w_xfer) begin
          w_period_nxt = r_period_cnt + 32'd1;
          if (w_last) begin
            w_state_nxt = DONE;
          end else if (STALL_EN && ((r_period_cnt + 32'd1) == 32'(STALL_PERIOD))) begin
            w_state_nxt  = STALL;
            w_period_nxt = '0;
            w_stall_nxt  = 32'(STALL_CYCLES);
          end
        end
      end
      STALL: begin
        w_stall_nxt = r_stall_cnt - 32'd1;
        if (r_stall_cnt <= 32'd1) begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  // Sticky error flag, set by any mismatching accepted token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_error <= 1'b0;
    end else if (w_mismatch) begin
      r_error <= 1'b1;
    end
  end

  handshake_sat_counter #(.WIDTH(CNT_WIDTH)) u_token_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_inc   (w_xfer),
    .o_count (token_count)
  );

  handshake_sat_counter #(.WIDTH(CNT_WIDTH)) u_mismatch_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_inc   (w_mismatch),
    .o_count (mismatch_count)
  );

`ifdef HANDSHAKE_CONST_SINK_CAPTURE_EN
  logic [DATA_WIDTH-1:0] r_first_bad_data;
  logic [CNT_WIDTH-1:0]  r_first_bad_idx;

  // Capture only the first mismatch; r_error still 0 marks it as first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first_bad_data <= '0;
      r_first_bad_idx  <= '0;
    end else if (w_mismatch && !r_error) begin
      r_first_bad_data <= s_if.ins;
      r_first_bad_idx  <= token_count;
    end
  end

  assign first_bad_data = r_first_bad_data;
  assign first_bad_idx  = r_first_bad_idx;
`else
  assign first_bad_data = '0;
  assign first_bad_idx  = '0;
`endif

endmodule

// File: tb/tb_handshake_const_sink.sv
// Scoreboard bench for handshake_const_sink: three configurations driven in
// lock-step (no stall, periodic stall, 4-bit saturating counters).
module tb_handshake_const_sink;

  localparam logic [31:0] EXPV = 32'h4923_0CBB;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
  localparam int unsigned P_EC  [3] = '{16, 40, 20};
  localparam int unsigned P_PER [3] = '{0, 4, 0};
  localparam int unsigned P_CYC [3] = '{2, 2, 2};
  localparam int unsigned P_MAX [3] = '{65535, 65535, 15};

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] tc;
    logic [31:0] mc;
    logic [31:0] fbd;
    logic [31:0] fbi;
    logic        err;
    logic        done;
    logic        rdy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sbq[$];

  handshake_const_sink_if #(.DATA_WIDTH(32)) ifa ();
  handshake_const_sink_if #(.DATA_WIDTH(32)) ifb ();
  handshake_const_sink_if #(.DATA_WIDTH(32)) ifc ();

  logic [15:0] a_tc, a_mc, a_fbi, b_tc, b_mc, b_fbi;
  logic [3:0]  c_tc, c_mc, c_fbi;
  logic [31:0] a_fbd, b_fbd, c_fbd;
  logic        a_err, a_done, b_err, b_done, c_err, c_done;

  handshake_const_sink #(.DATA_WIDTH(32), .EXPECTED(EXPV), .EXPECT_COUNT(16),
    .CNT_WIDTH(16), .STALL_PERIOD(0), .STALL_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .s_if(ifa), .token_count(a_tc), .mismatch_count(a_mc),
    .error(a_err), .done(a_done), .first_bad_data(a_fbd), .first_bad_idx(a_fbi));

  handshake_const_sink #(.DATA_WIDTH(32), .EXPECTED(EXPV), .EXPECT_COUNT(40),
    .CNT_WIDTH(16), .STALL_PERIOD(4), .STALL_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .s_if(ifb), .token_count(b_tc), .mismatch_count(b_mc),
    .error(b_err), .done(b_done), .first_bad_data(b_fbd), .first_bad_idx(b_fbi));

  handshake_const_sink #(.DATA_WIDTH(32), .EXPECTED(EXPV), .EXPECT_COUNT(20),
    .CNT_WIDTH(4), .STALL_PERIOD(0), .STALL_CYCLES(2)) dut_c (
    .clk(clk), .rst(rst), .s_if(ifc), .token_count(c_tc), .mismatch_count(c_mc),
    .error(c_err), .done(c_done), .first_bad_data(c_fbd), .first_bad_idx(c_fbi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: true token count, mismatches, stall cycles still owed.
  int unsigned m_tc[3], m_mc[3], m_since[3], m_stall[3];
  logic [31:0] m_fbd[3], m_fbi[3];
  bit          m_err[3], m_done[3];

  function automatic int unsigned sat(int i, int unsigned v);
    return (v > P_MAX[i]) ? P_MAX[i] : v;
  endfunction

  function automatic bit model_ready(int i);
    return !m_done[i] && (m_stall[i] == 0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tc[i] = 0; m_mc[i] = 0; m_since[i] = 0; m_stall[i] = 0;
      m_fbd[i] = '0; m_fbi[i] = '0; m_err[i] = 0; m_done[i] = 0;
    end
  endfunction

  function automatic void model_step(int i, bit v, logic [31:0] d);
    int unsigned pre;
    if (model_ready(i) && v) begin
      pre = sat(i, m_tc[i]);
      m_tc[i]++;
      if (d != EXPV) begin
`ifdef HANDSHAKE_CONST_SINK_CAPTURE_EN
        if (!m_err[i]) begin
          m_fbd[i] = d;
          m_fbi[i] = pre;
        end
`endif
        m_err[i] = 1;
        m_mc[i]++;
      end
      if (pre + 1 == P_EC[i]) begin
        m_done[i] = 1;
      end else begin
        m_since[i]++;
        if (P_PER[i] != 0 && P_CYC[i] != 0 && m_since[i] == P_PER[i]) begin
          m_since[i] = 0;
          m_stall[i] = P_CYC[i];
        end
      end
    end else if (!model_ready(i) && m_stall[i] > 0) begin
      m_stall[i]--;
    end
  endfunction

  function automatic exp_t actual(int i);
    exp_t a;
    a.inst = 2'(i);
    case (i)
      0: begin a.tc = 32'(a_tc); a.mc = 32'(a_mc); a.fbd = a_fbd; a.fbi = 32'(a_fbi);
               a.err = a_err; a.done = a_done; a.rdy = ifa.ins_ready; end
      1: begin a.tc = 32'(b_tc); a.mc = 32'(b_mc); a.fbd = b_fbd; a.fbi = 32'(b_fbi);
               a.err = b_err; a.done = b_done; a.rdy = ifb.ins_ready; end
      default: begin a.tc = 32'(c_tc); a.mc = 32'(c_mc); a.fbd = c_fbd; a.fbi = 32'(c_fbi);
               a.err = c_err; a.done = c_done; a.rdy = ifc.ins_ready; end
    endcase
    return a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(exp_t a, exp_t e, string tag);
    string p;
    p = $sformatf("%s.i%0d", tag, e.inst);
    chk({p, ".token_count"},    a.tc,  e.tc);
    chk({p, ".mismatch_count"}, a.mc,  e.mc);
    chk({p, ".error"},          32'(a.err),  32'(e.err));
    chk({p, ".done"},           32'(a.done), 32'(e.done));
    chk({p, ".ins_ready"},      32'(a.rdy),  32'(e.rdy));
    chk({p, ".first_bad_data"}, a.fbd, e.fbd);
    chk({p, ".first_bad_idx"},  a.fbi, e.fbi);
  endtask

  task automatic drive(int i, bit v, logic [31:0] d);
    case (i)
      0:       begin ifa.ins_valid = v; ifa.ins = d; end
      1:       begin ifb.ins_valid = v; ifb.ins = d; end
      default: begin ifc.ins_valid = v; ifc.ins = d; end
    endcase
  endtask

  // Monitor: just after each rising edge, compare every pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp_all(actual(int'(e.inst)), e, "sb");
      end
    end
  end

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0);
    #1;
    z = '0;
    z.rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      z.inst = 2'(i);
      cmp_all(actual(i), z, "rst");
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle of stimulus. mode 0: continuous valid, bad token 5;
  // mode 1: random valid, bad tokens 2 and 7; mode 2: fully random.
  task automatic step(int mode);
    exp_t e;
    bit v;
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      d = EXPV;
      case (mode)
        0: begin v = 1; if (m_tc[i] == 5) d = BAD; end
        1: begin v = ($urandom_range(3, 0) != 0); if (m_tc[i] == 2 || m_tc[i] == 7) d = BAD; end
        default: begin
          v = ($urandom_range(3, 0) != 0);
          if ($urandom_range(3, 0) == 0) begin
            d = $urandom();
            if (d == EXPV) d = ~d;
          end
        end
      endcase
      drive(i, v, d);
      model_step(i, v, d);
      e.inst = 2'(i);
      e.tc   = sat(i, m_tc[i]);
      e.mc   = sat(i, m_mc[i]);
      e.fbd  = m_fbd[i];
      e.fbi  = m_fbi[i];
      e.err  = m_err[i];
      e.done = m_done[i];
      e.rdy  = model_ready(i);
      sbq.push_back(e);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0);
    model_reset();

    do_reset();
    for (int n = 0; n < 64; n++) step(0);

    // Reset landing in the middle of a stall window on the stalling instance.
    do_reset();
    for (int n = 0; n < 20 && !(m_stall[1] > 0 && m_tc[1] >= 3); n++) step(0);
    chk("reach_stall", 32'(m_stall[1] > 0), 32'd1);
    do_reset();
    for (int n = 0; n < 8; n++) step(0);

    do_reset();
    for (int n = 0; n < 80; n++) step(1);

    do_reset();
    for (int n = 0; n < 300; n++) step(2);

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
